// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: sampling strobe and raw levels in, conditioned
// level and pulse outputs back. master = button source / consumer, slave = conditioner.
interface btn_conditioner_if #(
  parameter int N_BTN = 3
);
  logic             clk_en;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output clk_en,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  clk_en,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, clk_en-sampled debounce and a
// per-button IDLE/HELD/LONG FSM producing press/release/long pulses.
// Optional auto-repeat of btn_press while in LONG: define BTN_REPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN        = 3,
  parameter int DB_SAMPLES   = 3,
  parameter int LONG_TICKS   = 1526,
  parameter int REPEAT_TICKS = 191
) (
  input  logic              clk,
  input  logic              rst,
  btn_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } state_e;

  localparam int          HOLD_W  = $clog2(LONG_TICKS + 1);
  localparam logic [3:0]  DB_LAST = 4'(DB_SAMPLES);
`ifdef BTN_REPEAT_EN
  localparam int          REP_W   = $clog2(REPEAT_TICKS + 1);
`endif

  if (DB_SAMPLES < 2 || DB_SAMPLES > 15 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_conditioner: parameter out of legal range");
  end

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] long_w;

  // NOTE: non-blocking assignments are what make this a true two-stage chain;
  // with blocking ones sync2_q would take btn_raw in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    logic [3:0]        db_q, db_d;
    logic              stable_q, stable_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ev_press_q, ev_press_d;
    logic              ev_rel_q, ev_rel_d;
    logic              ev_long_q, ev_long_d;
    logic              press_q, rel_q, long_q;
`ifdef BTN_REPEAT_EN
    logic [REP_W-1:0]  rep_q, rep_d;
`endif

    // NOTE: every _d starts from its _q (or 0 for events) so that no path
    // through this block leaves a variable unassigned and infers a latch.
    always_comb begin
      db_d       = db_q;
      stable_d   = stable_q;
      state_d    = state_q;
      hold_d     = hold_q;
      ev_press_d = 1'b0;
      ev_rel_d   = 1'b0;
      ev_long_d  = 1'b0;
`ifdef BTN_REPEAT_EN
      rep_d      = rep_q;
`endif

      if (bus.clk_en) begin
        // Debounce: count disagreeing samples, flip on the DB_SAMPLES-th one.
        if (sync2_q[b] != stable_q) begin
          if (db_q + 4'd1 == DB_LAST) begin
            stable_d = ~stable_q;
            db_d     = '0;
          end else begin
            db_d = db_q + 4'd1;
          end
        end else begin
          db_d = '0;
        end

        // The FSM reacts to the level decided in this same sample.
        unique case (state_q)
          ST_IDLE: begin
            if (stable_d) begin
              state_d    = ST_HELD;
              hold_d     = '0;
              ev_press_d = 1'b1;
            end
          end
          ST_HELD: begin
            if (!stable_d) begin
              state_d  = ST_IDLE;
              ev_rel_d = 1'b1;
            end else if (hold_q + 1'b1 == HOLD_W'(LONG_TICKS)) begin
              state_d   = ST_LONG;
              hold_d    = hold_q + 1'b1;
              ev_long_d = 1'b1;
`ifdef BTN_REPEAT_EN
              rep_d     = '0;
`endif
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          ST_LONG: begin
            if (!stable_d) begin
              state_d  = ST_IDLE;
              ev_rel_d = 1'b1;
`ifdef BTN_REPEAT_EN
              rep_d    = '0;
            end else if (rep_q + 1'b1 == REP_W'(REPEAT_TICKS)) begin
              rep_d      = '0;
              ev_press_d = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
`endif
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Events are captured at the deciding edge and re-registered, so every
    // pulse appears exactly one clk after that edge and lasts one clk.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_q       <= '0;
        stable_q   <= 1'b0;
        state_q    <= ST_IDLE;
        hold_q     <= '0;
        ev_press_q <= 1'b0;
        ev_rel_q   <= 1'b0;
        ev_long_q  <= 1'b0;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
        long_q     <= 1'b0;
`ifdef BTN_REPEAT_EN
        rep_q      <= '0;
`endif
      end else begin
        db_q       <= db_d;
        stable_q   <= stable_d;
        state_q    <= state_d;
        hold_q     <= hold_d;
        ev_press_q <= ev_press_d;
        ev_rel_q   <= ev_rel_d;
        ev_long_q  <= ev_long_d;
        press_q    <= ev_press_q;
        rel_q      <= ev_rel_q;
        long_q     <= ev_long_q;
`ifdef BTN_REPEAT_EN
        rep_q      <= rep_d;
`endif
      end
    end

    assign level_w[b]   = stable_q;
    assign press_w[b]   = press_q;
    assign release_w[b] = rel_q;
    assign long_w[b]    = long_q;
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_long    = long_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_SAMPLES=3, LONG_TICKS=8,
// REPEAT_TICKS=4; clk_en strobes once every 4 clk.
module tb_btn_conditioner;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN(N), .DB_SAMPLES(3), .LONG_TICKS(8), .REPEAT_TICKS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;
  int p_cnt[N], p_at[N], p_ph[N];
  int r_cnt[N], r_at[N], r_ph[N];
  int l_cnt[N], l_at[N], l_ph[N];

  task automatic clear_mon();
    for (int i = 0; i < N; i++) begin
      p_cnt[i] = 0; p_at[i] = -1; p_ph[i] = -1;
      r_cnt[i] = 0; r_at[i] = -1; r_ph[i] = -1;
      l_cnt[i] = 0; l_at[i] = -1; l_ph[i] = -1;
    end
  endtask

  // s = strobes issued so far in this run, ph = clk since the last strobe edge
  task automatic sample(input int s, input int ph);
    for (int i = 0; i < N; i++) begin
      if (bus.btn_press[i])   begin p_cnt[i]++; p_at[i] = s; p_ph[i] = ph; end
      if (bus.btn_release[i]) begin r_cnt[i]++; r_at[i] = s; r_ph[i] = ph; end
      if (bus.btn_long[i])    begin l_cnt[i]++; l_at[i] = s; l_ph[i] = ph; end
      if (bus.btn_press[i] && bus.btn_release[i]) overlap++;
    end
  endtask

  task automatic run(input int n);
    int s;
    int ph;
    s  = 0;
    ph = 0;
    clear_mon();
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) begin
        bus.clk_en = (c == 3);
        @(posedge clk); #1;
        if (c == 3) begin s++; ph = 0; end
        else ph++;
        sample(s, ph);
      end
    end
    bus.clk_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      ph++;
      sample(s, ph);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.clk_en = 1'b0; bus.btn_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %b exp 0", {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int tot;
    run(20);
    tot = 0;
    for (int i = 0; i < N; i++) tot += p_cnt[i] + r_cnt[i] + l_cnt[i];
    checks++;
    if (tot !== 0) begin failures++; $display("FAIL idle_pulses got %0d exp 0", tot); end
    checks++;
    if (bus.btn_level !== 3'b000) begin failures++; $display("FAIL idle_level got %b exp 000", bus.btn_level); end
  endtask

  task automatic test_press_release();
    bus.btn_raw = 3'b001;
    run(2);
    checks++;
    if (bus.btn_level !== 3'b000 || p_cnt[0] !== 0) begin
      failures++; $display("FAIL early_press level=%b presses=%0d exp 000/0", bus.btn_level, p_cnt[0]);
    end
    run(1);
    checks++;
    if (p_cnt[0] !== 1 || p_at[0] !== 1 || p_ph[0] !== 1) begin
      failures++; $display("FAIL press0 cnt=%0d at=%0d ph=%0d exp 1/1/1", p_cnt[0], p_at[0], p_ph[0]);
    end
    checks++;
    if (bus.btn_level !== 3'b001 || p_cnt[1] + p_cnt[2] !== 0) begin
      failures++; $display("FAIL press0_iso level=%b others=%0d exp 001/0", bus.btn_level, p_cnt[1] + p_cnt[2]);
    end
    bus.btn_raw = 3'b000;
    run(3);
    checks++;
    if (r_cnt[0] !== 1 || r_at[0] !== 3 || r_ph[0] !== 1) begin
      failures++; $display("FAIL release0 cnt=%0d at=%0d ph=%0d exp 1/3/1", r_cnt[0], r_at[0], r_ph[0]);
    end
    checks++;
    if (bus.btn_level !== 3'b000 || p_cnt[0] !== 0) begin
      failures++; $display("FAIL release0_level level=%b presses=%0d exp 000/0", bus.btn_level, p_cnt[0]);
    end
  endtask

  task automatic test_bounce();
    int early_p;
    int rel;
    bus.btn_raw = 3'b010; run(2); early_p = p_cnt[1]; rel = r_cnt[1];
    bus.btn_raw = 3'b000; run(1); early_p += p_cnt[1]; rel += r_cnt[1];
    bus.btn_raw = 3'b010; run(3); rel += r_cnt[1];
    checks++;
    if (early_p !== 0) begin failures++; $display("FAIL bounce_early got %0d exp 0", early_p); end
    checks++;
    if (p_cnt[1] !== 1 || p_at[1] !== 3 || p_ph[1] !== 1) begin
      failures++; $display("FAIL bounce_press cnt=%0d at=%0d ph=%0d exp 1/3/1", p_cnt[1], p_at[1], p_ph[1]);
    end
    checks++;
    if (rel !== 0) begin failures++; $display("FAIL bounce_release got %0d exp 0", rel); end
    bus.btn_raw = 3'b000; run(3);
    checks++;
    if (r_cnt[1] !== 1) begin failures++; $display("FAIL bounce_final_release got %0d exp 1", r_cnt[1]); end
  endtask

  task automatic test_toggle();
    int tot;
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      bus.btn_raw[2] = ~bus.btn_raw[2];
      run(1);
      tot += p_cnt[2] + r_cnt[2] + l_cnt[2] + int'(bus.btn_level[2]);
    end
    checks++;
    if (tot !== 0) begin failures++; $display("FAIL toggle_activity got %0d exp 0", tot); end
  endtask

  task automatic test_freeze();
    int act;
    bus.btn_raw = 3'b010;
    run(2);
    act = p_cnt[1];
    bus.clk_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      act += int'(bus.btn_press[1]) + int'(bus.btn_level[1]);
    end
    checks++;
    if (act !== 0) begin failures++; $display("FAIL freeze_activity got %0d exp 0", act); end
    run(1);
    checks++;
    if (p_cnt[1] !== 1 || p_at[1] !== 1 || p_ph[1] !== 1) begin
      failures++; $display("FAIL freeze_resume cnt=%0d at=%0d ph=%0d exp 1/1/1", p_cnt[1], p_at[1], p_ph[1]);
    end
    bus.btn_raw = 3'b000; run(3);
    checks++;
    if (r_cnt[1] !== 1) begin failures++; $display("FAIL freeze_release got %0d exp 1", r_cnt[1]); end
  endtask

  task automatic test_long();
    bus.btn_raw = 3'b001;
    run(3);
    run(8);
    checks++;
    if (l_cnt[0] !== 1 || l_at[0] !== 8 || l_ph[0] !== 1) begin
      failures++; $display("FAIL long0 cnt=%0d at=%0d ph=%0d exp 1/8/1", l_cnt[0], l_at[0], l_ph[0]);
    end
    checks++;
    if (p_cnt[0] !== 0) begin failures++; $display("FAIL long0_press got %0d exp 0", p_cnt[0]); end
    bus.btn_raw = 3'b000;
    run(3);
    checks++;
    if (r_cnt[0] !== 1 || r_at[0] !== 3 || l_cnt[0] !== 0) begin
      failures++; $display("FAIL long0_release cnt=%0d at=%0d long=%0d exp 1/3/0", r_cnt[0], r_at[0], l_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_hold();
    int bad;
    bus.btn_raw = 3'b100;
    run(3);
    run(8);
    checks++;
    if (l_cnt[2] !== 1) begin failures++; $display("FAIL pre_reset_long got %0d exp 1", l_cnt[2]); end
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      bus.clk_en = c[0];
      @(posedge clk); #1;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long} !== '0) bad++;
    end
    rst = 1'b0;
    bus.clk_en = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL reset_hold_outputs got %0d nonzero cycles exp 0", bad); end
    run(3);
    checks++;
    if (p_cnt[2] !== 1 || p_at[2] !== 3 || p_ph[2] !== 1) begin
      failures++; $display("FAIL post_reset_press cnt=%0d at=%0d ph=%0d exp 1/3/1", p_cnt[2], p_at[2], p_ph[2]);
    end
    checks++;
    if (r_cnt[2] !== 0) begin failures++; $display("FAIL post_reset_release got %0d exp 0", r_cnt[2]); end
    bus.btn_raw = 3'b000; run(3);
    checks++;
    if (r_cnt[2] !== 1) begin failures++; $display("FAIL reset_final_release got %0d exp 1", r_cnt[2]); end
  endtask

  task automatic test_simultaneous();
    bus.btn_raw = 3'b011;
    run(3);
    checks++;
    if (p_cnt[0] !== 1 || p_cnt[1] !== 1 || p_at[0] !== 3 || p_at[1] !== 3 || p_ph[0] !== 1 || p_ph[1] !== 1) begin
      failures++;
      $display("FAIL simul_press cnt=%0d/%0d at=%0d/%0d ph=%0d/%0d exp 1/1 3/3 1/1",
               p_cnt[0], p_cnt[1], p_at[0], p_at[1], p_ph[0], p_ph[1]);
    end
    bus.btn_raw = 3'b000;
    run(3);
    checks++;
    if (r_cnt[0] !== 1 || r_cnt[1] !== 1 || r_at[0] !== 3 || r_at[1] !== 3) begin
      failures++;
      $display("FAIL simul_release cnt=%0d/%0d at=%0d/%0d exp 1/1 3/3", r_cnt[0], r_cnt[1], r_at[0], r_at[1]);
    end
  endtask

  task automatic test_repeat();
    bus.btn_raw = 3'b001;
    run(3);
    checks++;
    if (p_cnt[0] !== 1) begin failures++; $display("FAIL repeat_first_press got %0d exp 1", p_cnt[0]); end
    run(20);
    checks++;
    if (l_cnt[0] !== 1 || l_at[0] !== 8) begin
      failures++; $display("FAIL repeat_long cnt=%0d at=%0d exp 1/8", l_cnt[0], l_at[0]);
    end
`ifdef BTN_REPEAT_EN
    checks++;
    if (p_cnt[0] !== 3 || p_at[0] !== 20 || p_ph[0] !== 1) begin
      failures++; $display("FAIL repeat_presses cnt=%0d last=%0d ph=%0d exp 3/20/1", p_cnt[0], p_at[0], p_ph[0]);
    end
`else
    checks++;
    if (p_cnt[0] !== 0) begin failures++; $display("FAIL repeat_presses got %0d exp 0", p_cnt[0]); end
`endif
    bus.btn_raw = 3'b000;
    run(3);
    checks++;
    if (r_cnt[0] !== 1 || p_cnt[0] !== 0) begin
      failures++; $display("FAIL repeat_release rel=%0d press=%0d exp 1/0", r_cnt[0], p_cnt[0]);
    end
  endtask

  initial begin
    bus.clk_en  = 1'b0;
    bus.btn_raw = '0;
    clear_mon();
    test_reset();
    test_idle();
    test_press_release();
    test_bounce();
    test_toggle();
    test_freeze();
    test_long();
    test_reset_mid_hold();
    test_simultaneous();
    test_repeat();
    checks++;
    if (overlap !== 0) begin failures++; $display("FAIL press_release_overlap got %0d exp 0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Front-end conditioner for the board pushbuttons. It synchronizes the raw btn inputs and debounces them on the shared clk_en sampling strobe. It then emits clean one-cycle press, release and long-press pulses plus a stable level per button. It sits directly upstream of the step/pause logic, stopwatch and traffic_light command inputs, and replaces the ad-hoc 3-bit shift-register edge detectors.

Parameters:
N_BTN, 3, number of buttons conditioned (bit 0 = btnS, 1 = btn1, 2 = btnR-spare)
DB_SAMPLES, 3, consecutive agreeing clk_en samples required to change stable level (legal range 2..15)
LONG_TICKS, 1526, clk_en samples a button must stay stable-high before btn_long fires (about 2 s at 763 Hz; must be >= 1)
REPEAT_TICKS, 191, clk_en samples between auto-repeat presses (used only with BTN_REPEAT_EN)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous reset, active-high; all state cleared on the rising clk edge while high
clk_en  input  1  one-clk-cycle sampling strobe from the top-level clock divider
btn_raw  input  N_BTN  asynchronous raw button levels
btn_level  output  N_BTN  debounced stable level
btn_press  output  N_BTN  one-clk pulse on debounced 0->1
btn_release  output  N_BTN  one-clk pulse on debounced 1->0
btn_long  output  N_BTN  one-clk pulse when held LONG_TICKS samples

Behaviour:
- Synchronizer: 2-flop chain on clk for every bit, running every cycle regardless of clk_en. sync = 2nd flop.
- Debounce, per bit, on clk_en cycles only:
  - If sync != stable, db_cnt increments. Otherwise db_cnt clears to 0.
  - When db_cnt would reach DB_SAMPLES, stable flips and db_cnt clears in that same cycle.
  - db_cnt width is 4 bits. It never exceeds DB_SAMPLES-1 after update.
- Per-bit FSM (3 states), advancing only on clk_en cycles except for the pulse logic:
  - IDLE (stable=0): on stable 0->1, go to HELD and clear hold_cnt.
  - HELD: hold_cnt increments each clk_en. When hold_cnt reaches LONG_TICKS, go to LONG. On stable 1->0, go to IDLE.
  - LONG: hold_cnt holds (saturates). On stable 1->0, go to IDLE.
- Pulses are registered, asserted exactly one clk cycle, on the cycle after the event clk_en edge:
  - btn_press: after the IDLE->HELD edge.
  - btn_release: after a HELD->IDLE or LONG->IDLE edge.
  - btn_long: after the HELD->LONG edge.
- Latency: a clean raw rising edge gives btn_press high 2 clk (sync) + DB_SAMPLES clk_en strobes + 1 clk.
- Widths: hold_cnt is clog2(LONG_TICKS+1) bits and saturates, never wraps.
- Boundaries:
  - A bounce (sync disagreement ending) before DB_SAMPLES clears db_cnt; no pulse.
  - A raw input toggling every sample never changes stable.
  - clk_en held low freezes all debounce/FSM state. Outputs settle to 0 except btn_level.
  - Buttons are independent; simultaneous events on several bits pulse together in the same cycle.
  - btn_press and btn_release never assert together on one bit.
- Reset, including mid-hold:
  - All outputs 0; stable=0, FSM=IDLE, counters 0, sync flops 0.
  - No release pulse is generated by reset.
  - A button still held after reset is re-debounced and produces btn_press after the normal latency.
  - rst has priority over clk_en.

Optional Feature:
BTN_REPEAT_EN:
- Defined: in LONG, a separate rep_cnt counts clk_en samples.
  - Every REPEAT_TICKS samples, btn_press pulses again for one clk cycle, then rep_cnt clears.
  - rep_cnt clears on LONG entry and on release.
  - btn_long still pulses once on LONG entry.
- Undefined: rep_cnt logic is absent. btn_press fires only on the IDLE->HELD edge.

Test Plan:
1. Reset release, btn_raw=0, 20 clk_en strobes (one every 4 clk) -> all outputs stay 0.
2. DB_SAMPLES=3: raw bit0 0->1 held -> btn_level[0]=1 on the 3rd clk_en after sync. btn_press[0]=1 for exactly 1 clk, the cycle after. Other bits stay 0.
3. Bounce: raw bit1 high for 2 strobes, low for 1, high for 3 -> a single btn_press[1], coincident with the 3rd strobe of the final high run (+1 clk). No release pulse.
4. LONG_TICKS=8: hold bit0 -> btn_long[0] pulses once 8 clk_en after the press edge. Release -> btn_release[0] pulses 3 strobes after the raw fall.
5. Assert rst while bit2 held in LONG, raw still high -> outputs 0 during rst, no btn_release. After rst deasserts, btn_press[2] pulses after 2 clk + 3 strobes + 1 clk.
6. With BTN_REPEAT_EN, REPEAT_TICKS=4, LONG_TICKS=8: hold 20 strobes past the press -> btn_long at strobe 8, btn_press repeats at strobes 12, 16, 20. Without the macro -> a single btn_press only.
